piso_stream: RTL and testbench

Parametrised parallel-in/serial-out converter with ready/valid handshakes on both sides. It accepts one frame of up to `LANES` words per handshake from the PE array result bus and emits the words one per cycle on a serial stream with back-pressure. A per-frame lane count, a last-word flag and a selectable lane order are provided. A two-deep frame buffer (shift stage plus holding stage) lets consecutive frames stream without bubbles. It sits between the PE array output and the serial result path, replacing the fixed-length, non-back-pressured converter.

---
 rtl/piso_stream_pkg.sv | 26 ++
 rtl/piso_stream_if.sv | 40 ++++
 rtl/piso_frame_buf.sv | 46 ++++
 rtl/piso_stream.sv | 203 ++++++++++++++++++++
 tb/tb_piso_stream.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_stream_pkg.sv
// -----------------------------------------------------------------------------
// piso_stream_pkg
// Shared definitions for the parallel-in/serial-out result stream:
//   PE_NUM / DATA_WIDTH : PE array geometry, source of the LANES/DW defaults
//   PISO_MSB_FIRST      : default lane order (0 = lane 0 first)
//   piso_state_t        : frame-buffer occupancy states
//   piso_clamp()        : clamps a requested lane count to the frame width
// -----------------------------------------------------------------------------
package piso_stream_pkg;

    localparam int PE_NUM         = 4;
    localparam int DATA_WIDTH     = 16;
    localparam bit PISO_MSB_FIRST = 1'b0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } piso_state_t;

    function automatic int unsigned piso_clamp(input int unsigned cnt,
                                               input int unsigned lanes);
        return (cnt > lanes) ? lanes : cnt;
    endfunction

endpackage

// File: rtl/piso_stream_if.sv
// -----------------------------------------------------------------------------
// piso_stream_if
// Handshake bundle between the PE array result bus, the serial result path
// and piso_stream.
//   in_valid/in_ready/in_data/in_count : parallel frame side
//   out_valid/out_ready/out_data/out_last/out_lane : serial word side
//   busy : any frame held or in flight
// modport slave  : the converter's view
// modport master : the producer/consumer (environment) view
// -----------------------------------------------------------------------------
interface piso_stream_if
    import piso_stream_pkg::*;
#(
    parameter int LANES = PE_NUM,
    parameter int DW    = DATA_WIDTH * 2
);
    localparam int CNT_W = $clog2(LANES + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_data;
    logic [CNT_W-1:0]      in_count;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic [CNT_W-1:0]      out_lane;
    logic                  busy;

    modport slave (
        input  in_valid, in_data, in_count, out_ready,
        output in_ready, out_valid, out_data, out_last, out_lane, busy
    );

    modport master (
        output in_valid, in_data, in_count, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_lane, busy
    );

endinterface

// File: rtl/piso_frame_buf.sv
// -----------------------------------------------------------------------------
// piso_frame_buf
// Holding stage H: parks one complete frame (data + clamped count) while the
// shift stage is still emitting the previous frame.
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : capture i_data/i_count
//   i_unload  : frame has moved to the shift stage; count cleared
//   i_data    : frame data, lane k at [(k+1)*DW-1:k*DW]
//   i_count   : lane count (already clamped, non-zero)
//   o_data    : held frame data
//   o_count   : held lane count (0 when empty)
// -----------------------------------------------------------------------------
module piso_frame_buf #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_unload,
    input  logic [LANES*DW-1:0] i_data,
    input  logic [CNT_W-1:0]    i_count,
    output logic [LANES*DW-1:0] o_data,
    output logic [CNT_W-1:0]    o_count
);

    logic [LANES*DW-1:0] r_data;
    logic [CNT_W-1:0]    r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_count <= i_count;
        end else if (i_unload) begin
            r_count <= '0;
        end
    end

    assign o_data  = r_data;
    assign o_count = r_count;

endmodule

// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
// Parallel-in/serial-out converter with ready/valid on both sides. One frame
// of up to LANES words is accepted per input handshake and emitted one word
// per cycle with back-pressure. A shift stage S plus the holding stage H
// (piso_frame_buf) let consecutive frames stream without bubbles.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : piso_stream_if.slave (in_valid/in_ready/in_data/in_count,
//          out_valid/out_ready/out_data/out_last/out_lane, busy)
//
//   state    | meaning
//   ---------+-------------------------------
//   ST_EMPTY | S and H empty
//   ST_SHIFT | S emitting a frame, H empty
//   ST_FULL  | S emitting a frame, H loaded
// -----------------------------------------------------------------------------
module piso_stream
    import piso_stream_pkg::*;
#(
    parameter int LANES     = PE_NUM,
    parameter int DW        = DATA_WIDTH * 2,
    parameter bit MSB_FIRST = PISO_MSB_FIRST
) (
    input  logic         clk,
    input  logic         rst,
    piso_stream_if.slave bus
);

    localparam int CNT_W = $clog2(LANES + 1);

    piso_state_t         r_state;
    piso_state_t         w_state_nxt;

    // shift stage: frame data, words remaining (incl. the one on the output),
    // and the lane currently presented
    logic [LANES*DW-1:0] r_s_data;
    logic [CNT_W-1:0]    r_s_rem;
    logic [CNT_W-1:0]    r_s_ptr;
    logic [LANES*DW-1:0] w_s_data_nxt;
    logic [CNT_W-1:0]    w_s_rem_nxt;
    logic [CNT_W-1:0]    w_s_ptr_nxt;

    logic                r_out_valid;
    logic [DW-1:0]       r_out_data;
    logic                r_out_last;
    logic [CNT_W-1:0]    r_out_lane;
    logic                r_in_ready;
    logic                r_busy;

    logic [CNT_W-1:0]    w_cnt;
    logic                w_acc;
    logic                w_cons;
    logic                w_last_cons;
    logic                w_s_load;
    logic                w_s_from_h;
    logic                w_s_adv;
    logic                w_h_load;
    logic                w_h_unload;
    logic [LANES*DW-1:0] w_h_data;
    logic [CNT_W-1:0]    w_h_count;
    logic [LANES*DW-1:0] w_src_data;
    logic [CNT_W-1:0]    w_src_cnt;
    logic [DW-1:0]       w_word_nxt;
    logic                w_last_nxt;
    logic                w_valid_nxt;

    assign w_cnt = CNT_W'(piso_clamp(32'(bus.in_count), 32'(LANES)));

    // a zero-lane frame completes its handshake but is otherwise ignored
    assign w_acc       = bus.in_valid & r_in_ready & (w_cnt != '0);
    assign w_cons      = r_out_valid & bus.out_ready;
    assign w_last_cons = w_cons & r_out_last;

    piso_frame_buf #(
        .LANES (LANES),
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_h_load),
        .i_unload (w_h_unload),
        .i_data   (bus.in_data),
        .i_count  (w_cnt),
        .o_data   (w_h_data),
        .o_count  (w_h_count)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_s_data_nxt = r_s_data;
        w_s_rem_nxt  = r_s_rem;
        w_s_ptr_nxt  = r_s_ptr;
        w_s_load     = 1'b0;
        w_s_from_h   = 1'b0;
        w_s_adv      = 1'b0;
        w_h_load     = 1'b0;
        w_h_unload   = 1'b0;
        w_word_nxt   = '0;

        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_s_load    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_cons) begin
                    // S frees up this edge, so a new frame bypasses H
                    if (w_acc) begin
                        w_s_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end else begin
                    w_s_adv = w_cons;
                    if (w_acc) begin
                        w_h_load    = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (w_last_cons) begin
                    w_s_load    = 1'b1;
                    w_s_from_h  = 1'b1;
                    w_h_unload  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_s_adv = w_cons;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase

        w_src_data = w_s_from_h ? w_h_data  : bus.in_data;
        w_src_cnt  = w_s_from_h ? w_h_count : w_cnt;

        if (w_s_load) begin
            w_s_data_nxt = w_src_data;
            w_s_rem_nxt  = w_src_cnt;
            w_s_ptr_nxt  = MSB_FIRST ? (w_src_cnt - CNT_W'(1)) : '0;
        end else if (w_s_adv) begin
            w_s_rem_nxt  = r_s_rem - CNT_W'(1);
            w_s_ptr_nxt  = MSB_FIRST ? (r_s_ptr - CNT_W'(1)) : (r_s_ptr + CNT_W'(1));
        end

        for (int k = 0; k < LANES; k++) begin
            if (w_s_ptr_nxt == CNT_W'(k)) begin
                w_word_nxt = w_s_data_nxt[k*DW +: DW];
            end
        end
    end

    // outputs are registered from the next shift-stage contents so a frame
    // loaded at an edge presents its first word straight after that edge
    assign w_valid_nxt = (w_state_nxt != ST_EMPTY);
    assign w_last_nxt  = (w_s_rem_nxt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_s_data <= '0;
            r_s_rem  <= '0;
            r_s_ptr  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_s_data <= w_s_data_nxt;
            r_s_rem  <= w_s_rem_nxt;
            r_s_ptr  <= w_s_ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_lane  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_valid_nxt ? w_word_nxt : '0;
            r_out_last  <= w_valid_nxt & w_last_nxt;
            r_out_lane  <= w_valid_nxt ? w_s_ptr_nxt : '0;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_busy      <= w_valid_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_lane  = r_out_lane;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int CW    = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [CW-1:0] lane;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    piso_stream_if #(.LANES(LANES), .DW(DW)) if0 ();
    piso_stream_if #(.LANES(LANES), .DW(DW)) if1 ();

    piso_stream #(.LANES(LANES), .DW(DW), .MSB_FIRST(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    piso_stream #(.LANES(LANES), .DW(DW), .MSB_FIRST(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // reference model: expected serial words of one frame
    task automatic model(input bit which, input logic [LANES*DW-1:0] d,
                         input int cnt, input bit msb);
        int   c;
        int   ln;
        exp_t e;
        c = (cnt > LANES) ? LANES : cnt;
        for (int i = 0; i < c; i++) begin
            ln     = msb ? (c - 1 - i) : i;
            e.data = d[ln*DW +: DW];
            e.last = (i == c - 1);
            e.lane = CW'(ln);
            if (which) q1.push_back(e);
            else       q0.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [LANES*DW-1:0] d, input int cnt);
        chk("in_ready0_at_offer", if0.in_ready, 1);
        if0.in_valid = 1'b1;
        if0.in_data  = d;
        if0.in_count = CW'(cnt);
        model(1'b0, d, cnt, 1'b0);
        tick();
        if0.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [LANES*DW-1:0] d, input int cnt);
        chk("in_ready1_at_offer", if1.in_ready, 1);
        if1.in_valid = 1'b1;
        if1.in_data  = d;
        if1.in_count = CW'(cnt);
        model(1'b1, d, cnt, 1'b1);
        tick();
        if1.in_valid = 1'b0;
    endtask

    task automatic drain0(input string tag);
        int n = 0;
        while (q0.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, q0.size(), 0);
    endtask

    task automatic drain1(input string tag);
        int n = 0;
        while (q1.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, q1.size(), 0);
    endtask

    // scoreboard monitors: every presented word must match the queue head,
    // also while stalled; the head is retired on the handshake
    always @(negedge clk) begin
        if (!rst && if0.out_valid) begin
            chk("mon0_word_expected", (q0.size() != 0), 1);
            if (q0.size() != 0) begin
                chk("mon0_data", if0.out_data, q0[0].data);
                chk("mon0_last", if0.out_last, q0[0].last);
                chk("mon0_lane", if0.out_lane, q0[0].lane);
                if (if0.out_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if1.out_valid) begin
            chk("mon1_word_expected", (q1.size() != 0), 1);
            if (q1.size() != 0) begin
                chk("mon1_data", if1.out_data, q1[0].data);
                chk("mon1_last", if1.out_last, q1[0].last);
                chk("mon1_lane", if1.out_lane, q1[0].lane);
                if (if1.out_ready) void'(q1.pop_front());
            end
        end
    end

    initial begin
        int k;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.in_count = '0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.in_count = '0; if1.out_ready = 1'b1;

        // reset values
        tick(); tick(); tick();
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_out_data",  if0.out_data,  0);
        chk("rst_out_last",  if0.out_last,  0);
        chk("rst_out_lane",  if0.out_lane,  0);
        chk("rst_busy",      if0.busy,      0);
        chk("rst_in_ready",  if0.in_ready,  1);
        chk("rst_in_ready1", if1.in_ready,  1);
        rst = 1'b0;
        tick();

        // single 4-lane frame, first word right after the accept edge
        send0({32'h4, 32'h3, 32'h2, 32'h1}, 4);
        chk("lat_out_valid", if0.out_valid, 1);
        chk("lat_out_data",  if0.out_data,  32'h1);
        chk("lat_out_lane",  if0.out_lane,  0);
        chk("lat_busy",      if0.busy,      1);
        drain0("drain_single");
        chk("single_idle_valid", if0.out_valid, 0);
        chk("single_idle_busy",  if0.busy,      0);
        tick();

        // back-to-back frames of 4 and 2 words: no idle cycle, FULL for 3 cycles
        send0({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4);
        chk("b2b_valid_0", if0.out_valid, 1);
        send0({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 2);
        chk("b2b_valid_1", if0.out_valid, 1);
        chk("b2b_in_ready_1", if0.in_ready, 0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("b2b_valid_%0d", c), if0.out_valid, 1);
            chk($sformatf("b2b_in_ready_%0d", c), if0.in_ready, (c <= 3) ? 0 : 1);
        end
        tick();
        chk("b2b_valid_end", if0.out_valid, 0);
        chk("b2b_drained", q0.size(), 0);
        tick();

        // back-pressure 1,0,0,1 with a second frame parked in H
        if0.out_ready = 1'b0;
        send0({32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4);
        send0({32'hD3, 32'hD2, 32'hD1, 32'hD0}, 3);
        chk("stall_in_ready_full", if0.in_ready, 0);
        k = 0;
        while (q0.size() != 0 && k < 80) begin
            if0.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            tick();
            k++;
        end
        if0.out_ready = 1'b1;
        chk("stall_drained", q0.size(), 0);
        chk("stall_idle_valid", if0.out_valid, 0);
        tick();

        // lane counts 0, 1 and 7
        send0({32'hE3, 32'hE2, 32'hE1, 32'hE0}, 0);
        chk("zero_out_valid", if0.out_valid, 0);
        chk("zero_busy",      if0.busy,      0);
        chk("zero_in_ready",  if0.in_ready,  1);
        tick(); tick();
        chk("zero_still_idle", if0.out_valid, 0);
        send0({32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1);
        chk("one_out_last", if0.out_last, 1);
        send0({32'h73, 32'h72, 32'h71, 32'h70}, 7);
        drain0("drain_one_seven");
        chk("seven_idle_valid", if0.out_valid, 0);
        tick();

        // reversed lane order, count 3
        send1({32'h40, 32'h30, 32'h20, 32'h10}, 3);
        chk("msb_first_lane", if1.out_lane, 2);
        chk("msb_first_last", if1.out_last, 0);
        drain1("drain_msb_first");
        chk("msb_idle_valid", if1.out_valid, 0);
        tick();

        // reset while FULL and stalled mid-frame
        if0.out_ready = 1'b0;
        send0({32'h93, 32'h92, 32'h91, 32'h90}, 4);
        send0({32'h83, 32'h82, 32'h81, 32'h80}, 2);
        chk("pre_rst_in_ready", if0.in_ready, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", if0.out_valid, 0);
        chk("mid_rst_out_data",  if0.out_data,  0);
        chk("mid_rst_out_last",  if0.out_last,  0);
        chk("mid_rst_out_lane",  if0.out_lane,  0);
        chk("mid_rst_busy",      if0.busy,      0);
        chk("mid_rst_in_ready",  if0.in_ready,  1);
        q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        if0.out_ready = 1'b1;
        tick();
        chk("post_rst_idle", if0.out_valid, 0);
        send0({32'h14, 32'h13, 32'h12, 32'h11}, 4);
        chk("post_rst_first", if0.out_data, 32'h11);
        drain0("drain_post_rst");
        chk("post_rst_idle_end", if0.out_valid, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
